// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a power-of-two TX FIFO feeding a framer with configurable
// data width, parity and stop bits, timed by an internal baud divider.
module uart_tx_fifo #(
  parameter int FREQ       = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          serial_out
);

  localparam int DIV = FREQ / BAUDRATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(STOP_BITS * DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   DEPTH_L  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          level_q, level_d;
  logic                 full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // Admission uses the registered full flag, so a pop on the same edge never frees room.
  assign push     = wr_en && !full_q;
  assign head     = mem_q[rd_ptr_q];
  assign head_par = (PARITY == 2) ? ^head : ~^head;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = wr_en && full_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == DEPTH_L);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // The baud counter restarts on every load, keeping bit edges locked to the frame start.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
          shift_d = head;
          par_d   = head_par;
        end
      end
      S_START: begin
        if (baud_q == BIT_END) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BIT_END) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (baud_q == BIT_END) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == STOP_END) begin
          baud_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = S_START;
            shift_d = head;
            par_d   = head_par;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    serial_out = 1'b1;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_START:  serial_out = 1'b0;
      S_DATA:   serial_out = shift_q[0];
      S_PARITY: serial_out = par_q;
      default:  serial_out = 1'b1;
    endcase
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule
